spi_target: RTL and testbench
=============================

SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 SHALL have parameter REG_COUNT, default 16, number of 8-bit registers (power of two, 2..128).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on SPI inputs (>=2).
REQ-003 SHALL have io_clock  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have io_resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have io_spi_sclk  input  1  SPI serial clock from initiator (async to io_clock).
REQ-006 SHALL have io_spi_ss  input  1  active-low target select.
REQ-007 SHALL have io_spi_mosi  input  1  initiator-to-target data.
REQ-008 SHALL have io_spi_miso  output  1  target-to-initiator data.
REQ-009 SHALL have io_spi_misoEn  output  1  high while the target drives miso (ss synchronized low).
REQ-010 SHALL have io_regAddr  input  log2(REG_COUNT)  local port address.
REQ-011 SHALL have io_regRdata  output  8  combinational read of register[io_regAddr].
REQ-012 SHALL have io_regWe/io_regWdata  input  1/8  local write strobe and data.

Function
REQ-013 SHALL operate in SPI mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit bytes; io_clock >= 4x sclk.
REQ-014 SHALL pass sclk, ss, mosi through SYNC_STAGES flops; edges detected on the synchronized sclk; rising edge samples mosi, falling edge shifts miso.
REQ-015 SHALL implement FSM IDLE, CMD, WRITE, READ; IDLE->CMD on synchronized ss falling.
REQ-016 SHALL treat byte 1 as the command: bit7=1 read, 0 write; bits[log2(REG_COUNT)-1:0] start address; other bits ignored.
REQ-017 SHALL, on the 8th rising edge in CMD, load the address pointer and move to WRITE or READ.
REQ-018 SHALL in WRITE store each completed byte into register[ptr] on the cycle after its 8th rising edge, then increment ptr.
REQ-019 SHALL in READ load register[ptr] into the shift-out register on the 8th rising edge of the previous byte, present its MSB on miso before the next rising edge, then increment ptr.
REQ-020 SHALL wrap ptr from REG_COUNT-1 to 0.
REQ-021 SHALL drive miso 0 during CMD and whenever ss is high.
REQ-022 SHALL on ss rising in any state discard any partial byte, commit nothing further, return to IDLE within 1 cycle of the synchronized edge.
REQ-023 SHALL give SPI write priority when io_regWe and an SPI write target the same register in the same cycle; different addresses both commit.
REQ-024 SHALL ignore sclk edges while ss is high.
REQ-025 SHALL, in READ, return the value held at load time; a later local write to that address does not alter the in-flight byte.

Reset
REQ-026 SHALL on io_resetn low immediately force FSM IDLE, ptr 0, bit counter 0, shift registers 0, all registers 0x00, miso 0, misoEn 0, synchronizers to idle levels (sclk 0, ss 1).
REQ-027 SHALL, if reset deasserts while ss is low, stay IDLE until the next ss falling edge.

Configuration
REQ-028 SHALL, with SPI_TARGET_IRQ_EN defined, add output io_irq (1 bit), pulsed high exactly one cycle per register committed by an SPI write, reset 0.
REQ-029 SHALL, without SPI_TARGET_IRQ_EN, omit io_irq and its logic; all other behaviour identical.

Verification
REQ-030 SHALL cover: ss low, bytes 0x03,0xA5,0x5A, ss high -> reg[3]=0xA5, reg[4]=0x5A, reg[5] unchanged.
REQ-031 SHALL cover: local writes reg[0xF]=0x11, reg[0]=0x22; SPI 0x8F then two dummy bytes -> miso returns 0x11 then 0x22 (wrap).
REQ-032 SHALL cover: 0x02 then 5 bits of 0xFF, ss high -> reg[2] unchanged, next transaction 0x82 reads old value.
REQ-033 SHALL cover: SPI write to reg[1] with io_regWe, io_regAddr=1 in commit cycle -> reg[1] holds SPI data; with io_regAddr=6 both commit.
REQ-034 SHALL cover: io_resetn low mid-READ -> miso=0, misoEn=0 immediately, all registers 0x00 after release.
REQ-035 SHALL cover (SPI_TARGET_IRQ_EN): write 0x00,0x01,0x02,0x03 -> exactly three one-cycle io_irq pulses.

Source files
------------

// File: rtl/spi_target.sv
// SPI mode-0 target with an 8-bit register file and a local read/write port.
// Optional define SPI_TARGET_IRQ_EN adds io_irq: a one-cycle pulse per SPI-committed register.
module spi_target #(
  parameter int REG_COUNT   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         io_clock,
  input  logic                         io_resetn,
  input  logic                         io_spi_sclk,
  input  logic                         io_spi_ss,
  input  logic                         io_spi_mosi,
  output logic                         io_spi_miso,
  output logic                         io_spi_misoEn,
  input  logic [$clog2(REG_COUNT)-1:0] io_regAddr,
  output logic [7:0]                   io_regRdata,
  input  logic                         io_regWe,
  input  logic [7:0]                   io_regWdata
`ifdef SPI_TARGET_IRQ_EN
  ,
  output logic                         io_irq
`endif
);

  localparam int AW = $clog2(REG_COUNT);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WRITE, S_READ} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_sclk_prev;
  logic                   r_ss_prev;
  logic                   r_ss_armed;

  state_t                 r_state;
  logic [AW-1:0]          r_ptr;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_rx_shift;
  logic [7:0]             r_tx_shift;
  logic                   r_wr_pend;
  logic [7:0]             r_wr_data;
  logic                   r_miso_en;
  logic [7:0]             r_regs [REG_COUNT];

  logic                   w_sclk;
  logic                   w_ss;
  logic                   w_mosi;
  logic                   w_fill_done;
  logic                   w_sclk_rise;
  logic                   w_sclk_fall;
  logic                   w_ss_fall;
  logic [7:0]             w_rx_byte;
  logic                   w_byte_done;
  logic [AW-1:0]          w_cmd_addr;
  logic [REG_COUNT-1:0]   w_spi_hit;
  logic [REG_COUNT-1:0]   w_loc_hit;

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss        = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_fill_done = r_fill[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk & r_sclk_prev;
  // Only a falling edge seen after a genuine high level on ss starts a transaction.
  assign w_ss_fall   = r_ss_armed & r_ss_prev & ~w_ss;
  assign w_rx_byte   = {r_rx_shift[6:0], w_mosi};
  assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7);
  assign w_cmd_addr  = w_rx_byte[AW-1:0];

  always_ff @(posedge io_clock or negedge io_resetn) begin
    if (!io_resetn) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_fill      <= '0;
      r_sclk_prev <= 1'b0;
      r_ss_prev   <= 1'b1;
      r_ss_armed  <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], io_spi_sclk};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], io_spi_ss};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], io_spi_mosi};
      r_fill      <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_sclk_prev <= w_sclk;
      r_ss_prev   <= w_ss;
      r_ss_armed  <= r_ss_armed | (w_fill_done & w_ss);
    end
  end

  always_ff @(posedge io_clock or negedge io_resetn) begin
    if (!io_resetn) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      r_wr_pend  <= 1'b0;
      r_wr_data  <= '0;
      r_miso_en  <= 1'b0;
    end else begin
      r_wr_pend <= 1'b0;
      if (r_wr_pend) begin
        r_ptr <= r_ptr + AW'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (w_ss_fall) begin
            r_state    <= S_CMD;
            r_miso_en  <= 1'b1;
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_tx_shift <= '0;
          end
        end
        default: begin
          if (w_ss) begin
            r_state    <= S_IDLE;
            r_miso_en  <= 1'b0;
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_tx_shift <= '0;
          end else begin
            if (w_sclk_rise) begin
              r_rx_shift <= w_rx_byte;
              r_bit_cnt  <= r_bit_cnt + 3'd1;
            end
            // The fall right after a byte's 8th rise must keep the freshly loaded MSB.
            if (r_state == S_READ && w_sclk_fall && r_bit_cnt != 3'd0) begin
              r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            end
            if (w_byte_done) begin
              case (r_state)
                S_CMD: begin
                  if (w_rx_byte[7]) begin
                    r_state    <= S_READ;
                    r_tx_shift <= r_regs[w_cmd_addr];
                    r_ptr      <= w_cmd_addr + AW'(1);
                  end else begin
                    r_state <= S_WRITE;
                    r_ptr   <= w_cmd_addr;
                  end
                end
                S_WRITE: begin
                  r_wr_pend <= 1'b1;
                  r_wr_data <= w_rx_byte;
                end
                default: begin
                  r_tx_shift <= r_regs[r_ptr];
                  r_ptr      <= r_ptr + AW'(1);
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  // SPI commits take precedence over a same-cycle local write to the same register.
  generate
    for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_hit
      assign w_spi_hit[gi] = r_wr_pend && (r_ptr == AW'(gi));
      assign w_loc_hit[gi] = io_regWe && (io_regAddr == AW'(gi));
    end
  endgenerate

  always_ff @(posedge io_clock or negedge io_resetn) begin
    if (!io_resetn) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (w_spi_hit[i]) begin
          r_regs[i] <= r_wr_data;
        end else if (w_loc_hit[i]) begin
          r_regs[i] <= io_regWdata;
        end
      end
    end
  end

  assign io_regRdata   = r_regs[io_regAddr];
  assign io_spi_miso   = r_tx_shift[7];
  assign io_spi_misoEn = r_miso_en;

`ifdef SPI_TARGET_IRQ_EN
  logic r_irq;

  always_ff @(posedge io_clock or negedge io_resetn) begin
    if (!io_resetn) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_wr_pend;
    end
  end

  assign io_irq = r_irq;
`endif

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: local-port vector table plus hand-written SPI sequences.
// Build with SPI_TARGET_IRQ_EN defined to also exercise io_irq.
module tb_spi_target;

  localparam int SYNC_STAGES = 2;

  logic       io_clock = 1'b0;
  logic       io_resetn = 1'b0;
  logic       io_spi_sclk = 1'b0;
  logic       io_spi_ss = 1'b1;
  logic       io_spi_mosi = 1'b0;
  logic       io_spi_miso;
  logic       io_spi_misoEn;
  logic [3:0] io_regAddr = 4'h0;
  logic [7:0] io_regRdata;
  logic       io_regWe = 1'b0;
  logic [7:0] io_regWdata = 8'h00;

  int n_checks = 0;
  int n_errors = 0;

`ifdef SPI_TARGET_IRQ_EN
  logic io_irq;
  logic irq_prev = 1'b0;
  int   irq_high = 0;
  int   irq_rises = 0;

  always @(posedge io_clock) begin
    if (io_irq) irq_high++;
    if (io_irq && !irq_prev) irq_rises++;
    irq_prev <= io_irq;
  end
`endif

  spi_target #(.REG_COUNT(16), .SYNC_STAGES(SYNC_STAGES)) dut (
    .io_clock     (io_clock),
    .io_resetn    (io_resetn),
    .io_spi_sclk  (io_spi_sclk),
    .io_spi_ss    (io_spi_ss),
    .io_spi_mosi  (io_spi_mosi),
    .io_spi_miso  (io_spi_miso),
    .io_spi_misoEn(io_spi_misoEn),
    .io_regAddr   (io_regAddr),
    .io_regRdata  (io_regRdata),
    .io_regWe     (io_regWe),
    .io_regWdata  (io_regWdata)
`ifdef SPI_TARGET_IRQ_EN
    ,
    .io_irq       (io_irq)
`endif
  );

  always #5 io_clock = ~io_clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_reg(input logic [3:0] a, input logic [7:0] exp, input string name);
    @(negedge io_clock);
    io_regAddr = a;
    #1;
    check(name, io_regRdata, exp);
  endtask

  task automatic local_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge io_clock);
    io_regWe = 1'b1;
    io_regAddr = a;
    io_regWdata = d;
    @(negedge io_clock);
    io_regWe = 1'b0;
  endtask

  task automatic spi_bit(input logic b, output logic r);
    io_spi_mosi = b;
    io_spi_sclk = 1'b0;
    repeat (4) @(negedge io_clock);
    r = io_spi_miso;
    io_spi_sclk = 1'b1;
    repeat (4) @(negedge io_clock);
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], b);
      rx[i] = b;
    end
    io_spi_sclk = 1'b0;
    repeat (4) @(negedge io_clock);
    $display("spi byte tx=%h rx=%h", tx, rx);
  endtask

  // Writes a data byte and holds a local write active through the SPI commit cycle.
  task automatic spi_byte_hook(input logic [7:0] tx, input logic [3:0] la, input logic [7:0] ld);
    logic b;
    for (int i = 7; i >= 1; i--) spi_bit(tx[i], b);
    io_spi_mosi = tx[0];
    io_spi_sclk = 1'b0;
    repeat (4) @(negedge io_clock);
    io_spi_sclk = 1'b1;
    io_regWe = 1'b1;
    io_regAddr = la;
    io_regWdata = ld;
    repeat (SYNC_STAGES + 2) @(negedge io_clock);
    io_regWe = 1'b0;
    io_spi_sclk = 1'b0;
    repeat (4) @(negedge io_clock);
    $display("spi byte tx=%h with local write addr=%h data=%h", tx, la, ld);
  endtask

  task automatic ss_low();
    @(negedge io_clock);
    io_spi_ss = 1'b0;
    repeat (6) @(negedge io_clock);
  endtask

  task automatic ss_high();
    io_spi_ss = 1'b1;
    repeat (6) @(negedge io_clock);
  endtask

  initial begin
    logic [7:0] rx;
    logic       b;

    vecs[0]  = '{1'b0, 4'h0, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 4'h7, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 4'hF, 8'h00, 8'h00};
    vecs[3]  = '{1'b1, 4'hF, 8'h11, 8'h11};
    vecs[4]  = '{1'b1, 4'h0, 8'h22, 8'h22};
    vecs[5]  = '{1'b1, 4'h5, 8'h3C, 8'h3C};
    vecs[6]  = '{1'b1, 4'h2, 8'h96, 8'h96};
    vecs[7]  = '{1'b1, 4'h3, 8'hEE, 8'hEE};
    vecs[8]  = '{1'b0, 4'h5, 8'h00, 8'h3C};
    vecs[9]  = '{1'b1, 4'h7, 8'hFF, 8'hFF};
    vecs[10] = '{1'b0, 4'hF, 8'h00, 8'h11};

    repeat (3) @(negedge io_clock);
    check("reset_miso", {7'd0, io_spi_miso}, 8'h00);
    check("reset_misoen", {7'd0, io_spi_misoEn}, 8'h00);
    io_resetn = 1'b1;
    repeat (4) @(negedge io_clock);

    for (int i = 0; i < 11; i++) begin
      @(negedge io_clock);
      io_regWe = vecs[i].we;
      io_regAddr = vecs[i].addr;
      io_regWdata = vecs[i].wdata;
      @(negedge io_clock);
      io_regWe = 1'b0;
      #1;
      check($sformatf("vec%0d_rdata", i), io_regRdata, vecs[i].exp);
    end

    // Burst write from address 3.
    ss_low();
    check("cmd_misoen_high", {7'd0, io_spi_misoEn}, 8'h01);
    spi_byte(8'h03, rx);
    check("cmd_miso_zero", rx, 8'h00);
    spi_byte(8'hA5, rx);
    spi_byte(8'h5A, rx);
    ss_high();
    check("idle_misoen_low", {7'd0, io_spi_misoEn}, 8'h00);
    check_reg(4'h3, 8'hA5, "wr_reg3");
    check_reg(4'h4, 8'h5A, "wr_reg4");
    check_reg(4'h5, 8'h3C, "wr_reg5_untouched");

    // Read from 0xF wraps to 0.
    ss_low();
    spi_byte(8'h8F, rx);
    spi_byte(8'h00, rx);
    check("rd_reg15", rx, 8'h11);
    spi_byte(8'h00, rx);
    check("rd_wrap_reg0", rx, 8'h22);
    ss_high();

    // Aborted partial byte commits nothing.
    ss_low();
    spi_byte(8'h02, rx);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, b);
    io_spi_sclk = 1'b0;
    repeat (4) @(negedge io_clock);
    ss_high();
    $display("spi aborted after 5 bits");
    check_reg(4'h2, 8'h96, "abort_reg2");
    ss_low();
    spi_byte(8'h82, rx);
    spi_byte(8'h00, rx);
    check("abort_readback", rx, 8'h96);
    ss_high();

    // In-flight read byte ignores a later local write.
    ss_low();
    spi_byte(8'h83, rx);
    local_write(4'h3, 8'h12);
    spi_byte(8'h00, rx);
    check("inflight_read", rx, 8'hA5);
    ss_high();
    check_reg(4'h3, 8'h12, "inflight_local_wr");

    // Same-cycle SPI and local write collisions.
    ss_low();
    spi_byte(8'h01, rx);
    spi_byte_hook(8'hC3, 4'h1, 8'h44);
    ss_high();
    check_reg(4'h1, 8'hC3, "collide_same_addr");
    ss_low();
    spi_byte(8'h01, rx);
    spi_byte_hook(8'h5C, 4'h6, 8'h66);
    ss_high();
    check_reg(4'h1, 8'h5C, "collide_spi_reg1");
    check_reg(4'h6, 8'h66, "collide_local_reg6");

    // Asynchronous reset in the middle of a read.
    ss_low();
    spi_byte(8'h87, rx);
    check("pre_reset_miso", {7'd0, io_spi_miso}, 8'h01);
    check("pre_reset_misoen", {7'd0, io_spi_misoEn}, 8'h01);
    #2;
    io_resetn = 1'b0;
    #1;
    check("async_reset_miso", {7'd0, io_spi_miso}, 8'h00);
    check("async_reset_misoen", {7'd0, io_spi_misoEn}, 8'h00);
    repeat (3) @(negedge io_clock);
    io_resetn = 1'b1;
    repeat (8) @(negedge io_clock);
    check("post_reset_ss_low_idle", {7'd0, io_spi_misoEn}, 8'h00);
    ss_high();
    for (int a = 0; a < 16; a++) begin
      check_reg(4'(a), 8'h00, $sformatf("post_reset_reg%0d", a));
    end
    ss_low();
    spi_byte(8'h09, rx);
    spi_byte(8'hAB, rx);
    ss_high();
    check_reg(4'h9, 8'hAB, "post_reset_write");

`ifdef SPI_TARGET_IRQ_EN
    irq_high = 0;
    irq_rises = 0;
    ss_low();
    spi_byte(8'h00, rx);
    spi_byte(8'h01, rx);
    spi_byte(8'h02, rx);
    spi_byte(8'h03, rx);
    ss_high();
    repeat (4) @(negedge io_clock);
    check("irq_pulses", 8'(irq_rises), 8'd3);
    check("irq_high_cycles", 8'(irq_high), 8'd3);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
